apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter PORTS, default 3: number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT, default 0: maximum ACCESS cycles with m_pready low before abort; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 r_req  input  PORTS  per-requester transfer request, held high until r_ack.
REQ-006 r_addr  input  PORTS*32  per-requester address; requester i uses bits [i*32 +: 32].
REQ-007 r_write  input  PORTS  per-requester direction; 1 = write.
REQ-008 r_wdata  input  PORTS*32  per-requester write data.
REQ-009 r_ack  output  PORTS  one-cycle completion pulse to the granted requester.
REQ-010 r_rdata  output  32  read data, valid only while r_ack is high.
REQ-011 r_err  output  1  error flag, valid only while r_ack is high.
REQ-012 m_paddr, m_pwrite, m_psel, m_penable, m_pwdata  output  32/1/1/1/32  APB master bus.
REQ-013 m_prdata, m_pready, m_pslverr  input  32/1/1  APB completer return signals.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-015 IDLE: m_psel=0 and m_penable=0. If any r_req bit is high, the FSM SHALL grant one requester, latch that requester's addr/write/wdata into m_paddr/m_pwrite/m_pwdata registers, and go to SETUP.
REQ-016 SETUP: m_psel=1 and m_penable=0 for exactly one cycle, then go to ACCESS unconditionally.
REQ-017 ACCESS: m_psel=1 and m_penable=1 until m_pready=1 or the timeout fires.
REQ-018 ACCESS completion SHALL be combinational in the same cycle: r_ack[grant]=1, r_rdata=m_prdata, r_err=m_pslverr.
REQ-019 At completion, if any r_req bit is high, the FSM SHALL re-arbitrate, latch the new payload and go directly to SETUP; otherwise it SHALL go to IDLE.
REQ-020 A requester keeping r_req high in the cycle of its r_ack SHALL be treated as issuing a new request.
REQ-021 Arbitration SHALL be round-robin: search starts at last_grant+1, modulo PORTS. last_grant is updated only when a grant is issued.
REQ-022 m_paddr, m_pwrite and m_pwdata SHALL be stable from SETUP through the end of ACCESS; they hold their last value in IDLE.
REQ-023 While not completing, r_ack SHALL be all zeros, and r_rdata and r_err SHALL be 0.
REQ-024 Minimum transfer latency SHALL be 3 cycles from IDLE (arbitrate, SETUP, ACCESS) and 2 cycles back-to-back.
REQ-025 Timeout, when TIMEOUT>0: a counter clears on entry to ACCESS and increments on each ACCESS cycle with m_pready=0.
REQ-026 When that counter equals TIMEOUT, the arbiter SHALL complete the transfer with r_ack=1, r_err=1, r_rdata=0, and take the next state per REQ-019.
REQ-027 m_pready=1 in the same cycle as the timeout SHALL take precedence, giving a normal completion.
REQ-028 Requests that deassert before being granted SHALL be dropped with no r_ack.

Reset
REQ-029 Reset SHALL force, asynchronously: state=IDLE, m_psel=0, m_penable=0, m_paddr=0, m_pwrite=0, m_pwdata=0, last_grant=PORTS-1 (so requester 0 wins first), timeout counter=0.
REQ-030 While state is IDLE after reset, r_ack SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer without an r_ack.

Structure
REQ-032 Package apb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and the APB data/address width constant of 32.
REQ-033 Round-robin selection SHALL be a separate combinational sub-module, rr_pick.
- rr_pick inputs: request vector, last_grant.
- rr_pick outputs: grant index and a valid flag.

Verification
REQ-034 Single write: r_req[0]=1, addr 0x400, wdata 0xA5A5A5A5, m_pready tied 1 -> SETUP on cycle 1, ACCESS on cycle 2, r_ack[0] pulse on cycle 2, m_pwdata=0xA5A5A5A5.
REQ-035 Fairness: r_req=3'b111 held high continuously -> grant order 0,1,2,0,1,2 with a 2-cycle spacing between consecutive r_ack pulses.
REQ-036 Wait states: read to addr 0x1000 with m_pready low for 4 ACCESS cycles and m_prdata=0x12345678 -> r_ack on the 5th ACCESS cycle, r_rdata=0x12345678, r_err=0.
REQ-037 Timeout: TIMEOUT=8, m_pready stuck low -> r_ack with r_err=1 and r_rdata=0 after 8 ACCESS cycles, then m_psel=0.
REQ-038 Slave error: m_pslverr=1 with m_pready=1 -> r_err=1 in the r_ack cycle.
REQ-039 Reset during ACCESS -> m_psel and m_penable drop in the same cycle, no r_ack, and the next grant goes to requester 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB arbiter: bus width, FSM encoding and
// a small helper for index widths.
package apb_pkg;

   localparam int APB_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Bits needed to hold an index in 0..n-1, never less than one.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping
// modulo PORTS, and returns the first requesting index.
module rr_pick
   import apb_pkg::*;
#(
   parameter int PORTS = 3,
   localparam int IW = idx_w(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    idx,
   output logic             valid
);

   logic [IW-1:0] cand;

   // Walk the ring once starting just after the previous winner.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 1; k <= PORTS; k++) begin
         cand = IW'((int'(last) + k) % PORTS);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/apb_arbiter.sv
// Multi-requester APB master: round-robin arbitration in front of a
// single APB bus. Completion is reported combinationally in the final
// ACCESS cycle, and a new grant can be issued in that same cycle so
// back-to-back transfers take two cycles each.
//
// Requester handshake: r_req[i] is held high until r_ack[i] pulses for one
// cycle; r_rdata/r_err are meaningful only in that cycle and read as zero
// otherwise. A request still high in its ack cycle counts as a new request.
module apb_arbiter
   import apb_pkg::*;
#(
   parameter int PORTS   = 3,
   parameter int TIMEOUT = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PORTS-1:0]       r_req,
   input  logic [PORTS*APB_W-1:0] r_addr,
   input  logic [PORTS-1:0]       r_write,
   input  logic [PORTS*APB_W-1:0] r_wdata,
   output logic [PORTS-1:0]       r_ack,
   output logic [APB_W-1:0]       r_rdata,
   output logic                   r_err,
   output logic [APB_W-1:0]       m_paddr,
   output logic                   m_pwrite,
   output logic                   m_psel,
   output logic                   m_penable,
   output logic [APB_W-1:0]       m_pwdata,
   input  logic [APB_W-1:0]       m_prdata,
   input  logic                   m_pready,
   input  logic                   m_pslverr,
   output state_t                 dbg_state
);

   localparam int IW = idx_w(PORTS);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t           state, state_n;
   logic [IW-1:0]    grant, last_grant, pick_idx;
   logic             pick_valid, load, timed_out;
   logic [TW-1:0]    tcnt;
   logic [APB_W-1:0] sel_addr, sel_wdata;
   logic             sel_write;

   rr_pick #(.PORTS(PORTS)) u_pick (
      .req   (r_req),
      .last  (last_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign timed_out = (TIMEOUT > 0) && (tcnt == TW'(TIMEOUT));
   assign dbg_state = state;

   // Payload of the requester the picker currently selects.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (pick_idx == IW'(i)) begin
            sel_addr  = r_addr[i*APB_W +: APB_W];
            sel_wdata = r_wdata[i*APB_W +: APB_W];
            sel_write = r_write[i];
         end
      end
   end

   // Next state, grant load strobe and requester-side completion outputs.
   always_comb begin
      state_n   = state;
      load      = 1'b0;
      r_ack     = '0;
      r_rdata   = '0;
      r_err     = 1'b0;
      m_psel    = (state != IDLE);
      m_penable = (state == ACCESS);
      case (state)
         IDLE: begin
            if (pick_valid) begin
               load    = 1'b1;
               state_n = SETUP;
            end
         end
         SETUP: state_n = ACCESS;
         ACCESS: begin
            // A ready completer wins over a timeout in the same cycle.
            if (m_pready || timed_out) begin
               r_ack[grant] = 1'b1;
               if (m_pready) begin
                  r_rdata = m_prdata;
                  r_err   = m_pslverr;
               end else begin
                  r_err   = 1'b1;
               end
               if (pick_valid) begin
                  load    = 1'b1;
                  state_n = SETUP;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Grant bookkeeping and APB payload registers, updated only on a grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant      <= '0;
         last_grant <= IW'(PORTS - 1);
         m_paddr    <= '0;
         m_pwrite   <= 1'b0;
         m_pwdata   <= '0;
      end else if (load) begin
         grant      <= pick_idx;
         last_grant <= pick_idx;
         m_paddr    <= sel_addr;
         m_pwrite   <= sel_write;
         m_pwdata   <= sel_wdata;
      end
   end

   // Wait-state counter: cleared in SETUP (entry to ACCESS), counts stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
      end else if (state == SETUP) begin
         tcnt <= '0;
      end else if (TIMEOUT > 0 && state == ACCESS && !m_pready) begin
         tcnt <= tcnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: the driver pushes hand-computed
// completions into a queue, a monitor pops and compares on every r_ack.
module tb_apb_arbiter;
   import apb_pkg::*;

   localparam int PORTS = 3;

   typedef struct packed {
      logic [PORTS-1:0] ack;
      logic [31:0]      rdata;
      logic             err;
      logic [31:0]      cyc;
      logic [31:0]      paddr;
      logic             pwrite;
      logic [31:0]      pwdata;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [PORTS-1:0]     r_req;
   logic [PORTS*32-1:0]  r_addr;
   logic [PORTS-1:0]     r_write;
   logic [PORTS*32-1:0]  r_wdata;
   logic [PORTS-1:0]     r_ack;
   logic [31:0]          r_rdata;
   logic                 r_err;
   logic [31:0]          m_paddr;
   logic                 m_pwrite;
   logic                 m_psel;
   logic                 m_penable;
   logic [31:0]          m_pwdata;
   logic [31:0]          m_prdata;
   logic                 m_pready;
   logic                 m_pslverr;
   state_t               dbg_state;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic hold;
   int   c0, c1;

   apb_arbiter #(.PORTS(PORTS), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .r_req(r_req), .r_addr(r_addr), .r_write(r_write), .r_wdata(r_wdata),
      .r_ack(r_ack), .r_rdata(r_rdata), .r_err(r_err),
      .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_psel(m_psel),
      .m_penable(m_penable), .m_pwdata(m_pwdata),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
      .dbg_state(dbg_state)
   );

   // clock / cycle counter
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input logic [PORTS-1:0] ack, input logic [31:0] rdata,
                           input logic err, input int c, input logic [31:0] paddr,
                           input logic pwrite, input logic [31:0] pwdata);
      exp_t e;
      e.ack = ack; e.rdata = rdata; e.err = err; e.cyc = 32'(c);
      e.paddr = paddr; e.pwrite = pwrite; e.pwdata = pwdata;
      exp_q.push_back(e);
   endtask

   task automatic set_port(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
      r_addr[i*32 +: 32]  = a;
      r_write[i]          = w;
      r_wdata[i*32 +: 32] = d;
   endtask

   // Advance to posedge+1 of cycle t.
   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard monitor; also models requesters dropping r_req on their ack.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (r_ack != '0) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_ack: got ack=%b expected none (cycle %0d)", r_ack, cyc);
            end else begin
               e = exp_q.pop_front();
               check("ack_vec", 32'(r_ack), 32'(e.ack));
               check("ack_cycle", 32'(cyc), e.cyc);
               check("rdata", r_rdata, e.rdata);
               check("err", 32'(r_err), 32'(e.err));
               check("paddr_at_ack", m_paddr, e.paddr);
               check("pwrite_at_ack", 32'(m_pwrite), 32'(e.pwrite));
               check("pwdata_at_ack", m_pwdata, e.pwdata);
            end
            if (!hold) r_req = r_req & ~r_ack;
         end else begin
            check("quiet_rdata", r_rdata, 32'h0);
            check("quiet_err", 32'(r_err), 32'h0);
         end
      end
   endtask

   task automatic check_reset_values();
      check("rst_psel", 32'(m_psel), 0);
      check("rst_penable", 32'(m_penable), 0);
      check("rst_paddr", m_paddr, 0);
      check("rst_pwrite", 32'(m_pwrite), 0);
      check("rst_pwdata", m_pwdata, 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_ack", 32'(r_ack), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1; r_req = '0; hold = 1'b0;
      m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = '0;
      @(negedge clk);
      check_reset_values();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Bounded drain: all expected acks seen, bus idle, no requests left.
   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || dbg_state != IDLE || r_req != '0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_tests++;
      if (n >= 100) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d pending acks expected 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : main
      logic [31:0] fa_addr[3];
      logic [31:0] fa_data[3];
      logic        fa_wr[3];
      reset = 1'b1; r_req = '0; r_addr = '0; r_write = '0; r_wdata = '0;
      m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0; hold = 1'b0;
      fork
         monitor();
      join_none
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values();

      // single write, zero wait states
      do_reset();
      m_pready = 1'b1;
      set_port(0, 32'h400, 1'b1, 32'hA5A5A5A5);
      r_req = 3'b001;
      c0 = cyc;
      push_exp(3'b001, 32'h0, 1'b0, c0 + 2, 32'h400, 1'b1, 32'hA5A5A5A5);
      goto(c0 + 1);
      @(negedge clk);
      check("setup_state", 32'(dbg_state), 32'(SETUP));
      check("setup_psel", 32'(m_psel), 1);
      check("setup_penable", 32'(m_penable), 0);
      check("setup_paddr", m_paddr, 32'h400);
      check("setup_pwdata", m_pwdata, 32'hA5A5A5A5);
      goto(c0 + 2);
      @(negedge clk);
      check("access_psel", 32'(m_psel), 1);
      check("access_penable", 32'(m_penable), 1);
      goto(c0 + 3);
      @(negedge clk);
      check("idle_psel", 32'(m_psel), 0);
      check("idle_paddr_hold", m_paddr, 32'h400);
      wait_done("single_write");

      // fairness with all requests held high
      do_reset();
      fa_addr = '{32'h100, 32'h200, 32'h300};
      fa_data = '{32'h11111111, 32'h22222222, 32'h33333333};
      fa_wr   = '{1'b1, 1'b0, 1'b1};
      for (int p = 0; p < 3; p++) set_port(p, fa_addr[p], fa_wr[p], fa_data[p]);
      m_pready = 1'b1;
      m_prdata = 32'h77;
      hold = 1'b1;
      r_req = 3'b111;
      c0 = cyc;
      for (int k = 0; k < 6; k++) begin
         push_exp(3'(1 << (k % 3)), 32'h77, 1'b0, c0 + 2 + 2 * k,
                  fa_addr[k % 3], fa_wr[k % 3], fa_data[k % 3]);
      end
      goto(c0 + 12);
      r_req = '0;
      hold = 1'b0;
      wait_done("fairness");

      // read with four wait states
      do_reset();
      set_port(1, 32'h1000, 1'b0, 32'h0);
      m_prdata = 32'h12345678;
      r_req = 3'b010;
      c0 = cyc;
      push_exp(3'b010, 32'h12345678, 1'b0, c0 + 6, 32'h1000, 1'b0, 32'h0);
      goto(c0 + 4);
      @(negedge clk);
      check("wait_penable", 32'(m_penable), 1);
      check("wait_ack", 32'(r_ack), 0);
      goto(c0 + 6);
      m_pready = 1'b1;
      wait_done("wait_states");

      // timeout with completer stuck not-ready
      do_reset();
      set_port(2, 32'h2000, 1'b1, 32'hBEEF0002);
      m_prdata = 32'hDEADBEEF;
      r_req = 3'b100;
      c0 = cyc;
      push_exp(3'b100, 32'h0, 1'b1, c0 + 10, 32'h2000, 1'b1, 32'hBEEF0002);
      goto(c0 + 11);
      @(negedge clk);
      check("timeout_psel_after", 32'(m_psel), 0);
      check("timeout_state_after", 32'(dbg_state), 32'(IDLE));
      wait_done("timeout");

      // ready arriving in the timeout cycle completes normally
      do_reset();
      set_port(0, 32'h3000, 1'b0, 32'h0);
      m_prdata = 32'hCAFEF00D;
      r_req = 3'b001;
      c0 = cyc;
      push_exp(3'b001, 32'hCAFEF00D, 1'b0, c0 + 10, 32'h3000, 1'b0, 32'h0);
      goto(c0 + 10);
      m_pready = 1'b1;
      wait_done("timeout_precedence");

      // completer error
      do_reset();
      set_port(1, 32'h4000, 1'b1, 32'h0BAD0BAD);
      m_pready = 1'b1; m_pslverr = 1'b1; m_prdata = 32'h55;
      r_req = 3'b010;
      c0 = cyc;
      push_exp(3'b010, 32'h55, 1'b1, c0 + 2, 32'h4000, 1'b1, 32'h0BAD0BAD);
      wait_done("slverr");
      m_pslverr = 1'b0;

      // request withdrawn before being granted gets no ack
      do_reset();
      set_port(0, 32'h30, 1'b1, 32'h1111);
      set_port(1, 32'h40, 1'b1, 32'h2222);
      r_req = 3'b001;
      c0 = cyc;
      push_exp(3'b001, 32'h0, 1'b0, c0 + 4, 32'h30, 1'b1, 32'h1111);
      goto(c0 + 3);
      r_req[1] = 1'b1;
      goto(c0 + 4);
      r_req[1] = 1'b0;
      m_pready = 1'b1;
      wait_done("dropped_request");

      // reset in the middle of ACCESS, then arbitration restarts at 0
      do_reset();
      set_port(2, 32'h2000, 1'b0, 32'h0);
      r_req = 3'b100;
      c0 = cyc;
      goto(c0 + 3);
      reset = 1'b1;
      #1;
      check("midrst_psel", 32'(m_psel), 0);
      check("midrst_penable", 32'(m_penable), 0);
      check("midrst_paddr", m_paddr, 0);
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      set_port(0, 32'h10, 1'b1, 32'hA0);
      set_port(1, 32'h20, 1'b1, 32'hA1);
      set_port(2, 32'h24, 1'b1, 32'hA2);
      r_req = 3'b111;
      m_pready = 1'b1;
      m_prdata = 32'h0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      c1 = cyc;
      push_exp(3'b001, 32'h0, 1'b0, c1 + 2, 32'h10, 1'b1, 32'hA0);
      push_exp(3'b010, 32'h0, 1'b0, c1 + 4, 32'h20, 1'b1, 32'hA1);
      push_exp(3'b100, 32'h0, 1'b0, c1 + 6, 32'h24, 1'b1, 32'hA2);
      wait_done("reset_mid_access");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
